muldiv_ctrl: RTL

- Sequencer for the EXE-stage multiply/divide resources: a pipelined multiplier with fixed latency and AXI-stream divider cores.
- Accepts one MULT/MULTU/DIV/DIVU per issue and drives the cores with correct handshakes.
- Stalls the pipeline while the operation is in flight, then delivers a single-cycle HI/LO write.
- Handles pipeline flush and divide-by-zero.

---
 rtl/muldiv_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: EXE-stage sequencer for a fixed-latency pipelined multiplier
// and AXI-stream divider cores. Issues one op at a time, stalls the pipeline
// while it is in flight and returns a single-cycle HI/LO write strobe.
`timescale 1ns/1ps
module muldiv_ctrl #(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        stall,
  output logic        busy,
  output logic        hilo_we,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic [32:0] mul_a,
  output logic [32:0] mul_b,
  input  logic [65:0] mul_p,
  output logic        div_signed,
  output logic        div_dividend_tvalid,
  output logic [31:0] div_dividend_tdata,
  input  logic        div_dividend_tready,
  output logic        div_divisor_tvalid,
  output logic [31:0] div_divisor_tdata,
  input  logic        div_divisor_tready,
  input  logic        div_dout_tvalid,
  input  logic [63:0] div_dout_tdata
);

  localparam int CNT_W = $clog2(MUL_LAT + 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_MUL_WAIT = 3'd1;
  localparam logic [2:0] S_DIV_SEND = 3'd2;
  localparam logic [2:0] S_DIV_WAIT = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  logic [2:0]       state;
  logic             kill;
  logic [CNT_W-1:0] cnt;
  logic             dd_sent;
  logic             dv_sent;
  logic             dd_hs;
  logic             dv_hs;
  logic             send_done;
  logic             ext_a;
  logic             ext_b;
  logic             unused_mul_top;

  // Product bits above 64 are only sign extension of the 33x33 product.
  assign unused_mul_top = ^mul_p[65:64];

  // Channel handshakes; each tvalid stays up until its own transfer completes.
  always_comb begin
    div_dividend_tvalid = (state == S_DIV_SEND) && !dd_sent;
    div_divisor_tvalid  = (state == S_DIV_SEND) && !dv_sent;
    dd_hs     = div_dividend_tvalid && div_dividend_tready;
    dv_hs     = div_divisor_tvalid && div_divisor_tready;
    send_done = (dd_sent || dd_hs) && (dv_sent || dv_hs);
    ext_a     = !op[0] && src_a[31];
    ext_b     = !op[0] && src_b[31];
  end

  // Pipeline-facing status: stall while in flight, and while draining a
  // killed divide if EXE already presents the next op.
  always_comb begin
    stall = 1'b0;
    case (state)
      S_IDLE:                             stall = start && !flush;
      S_MUL_WAIT, S_DIV_SEND, S_DIV_WAIT: stall = !kill;
      default:                            stall = 1'b0;
    endcase
    if (kill && start) stall = 1'b1;
    busy    = (state != S_IDLE);
    hilo_we = (state == S_DONE) && !flush;
  end

  // Sequencer: issue, wait for the selected resource, capture HI/LO.
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= S_IDLE;
      kill               <= 1'b0;
      cnt                <= '0;
      dd_sent            <= 1'b0;
      dv_sent            <= 1'b0;
      hi_out             <= '0;
      lo_out             <= '0;
      mul_a              <= '0;
      mul_b              <= '0;
      div_signed         <= 1'b0;
      div_dividend_tdata <= '0;
      div_divisor_tdata  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !flush) begin
            mul_a <= {ext_a, src_a};
            mul_b <= {ext_b, src_b};
            if (!op[1]) begin
              cnt   <= CNT_W'(MUL_LAT);
              state <= S_MUL_WAIT;
            end else if (src_b == '0) begin
              hi_out <= src_a;
              lo_out <= '1;
              state  <= S_DONE;
            end else begin
              div_signed         <= !op[0];
              div_dividend_tdata <= src_a;
              div_divisor_tdata  <= src_b;
              dd_sent            <= 1'b0;
              dv_sent            <= 1'b0;
              state              <= S_DIV_SEND;
            end
          end
        end
        S_MUL_WAIT: begin
          if (flush) begin
            state <= S_IDLE;
          end else if (cnt == '0) begin
            hi_out <= mul_p[63:32];
            lo_out <= mul_p[31:0];
            state  <= S_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DIV_SEND: begin
          if (flush) kill <= 1'b1;
          if (dd_hs) dd_sent <= 1'b1;
          if (dv_hs) dv_sent <= 1'b1;
          // Flags are cleared on exit; this overrides a same-cycle set above.
          if (send_done) begin
            dd_sent <= 1'b0;
            dv_sent <= 1'b0;
            state   <= S_DIV_WAIT;
          end
        end
        S_DIV_WAIT: begin
          if (div_dout_tvalid) begin
            if (kill || flush) begin
              kill  <= 1'b0;
              state <= S_IDLE;
            end else begin
              hi_out <= div_dout_tdata[31:0];
              lo_out <= div_dout_tdata[63:32];
              state  <= S_DONE;
            end
          end else if (flush) begin
            kill <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
